// File: rtl/varredura_display_pkg.sv
// Shared display constants for the digit scanner and any reuse of the decoder.
//   SEG_APAGADO     : all segments off (active-low)
//   TABELA_SEG      : hex nibble to active-low {g,f,e,d,c,b,a}
//   largura_indice  : digit index width, never below 1 bit
package pkg_display;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  localparam logic [6:0] TABELA_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic int unsigned largura_indice(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/varredura_display_decodificador.sv
// Combinational hex to 7-segment decoder, active-low {g,f,e,d,c,b,a}.
//   nibble : 4-bit hex digit
//   seg_c  : active-low segment pattern
module decodificador_7seg
  import pkg_display::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = TABELA_SEG[nibble];
  end

endmodule

// File: rtl/varredura_display.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Each digit owns a slot of DIV_REFRESH cycles; the first GUARDA cycles of a
// slot keep every anode off to avoid ghosting. All outputs are registered and
// reflect the state and inputs of the previous cycle.
// Optional build macro VARREDURA_DIMMER_EN adds a 4-bit brightness PWM.
//   clk, rst_n     : clock, synchronous active-low reset
//   habilita       : 1 = scan; 0 = freeze scan and blank
//   dados          : packed hex nibbles, digit 0 rightmost
//   apagar         : per-digit blank mask
//   pontos         : per-digit decimal point request
//   brilho         : brightness 0..15 (VARREDURA_DIMMER_EN only)
//   anodos         : active-low one-hot digit enable
//   segmentos      : active-low segments {g,f,e,d,c,b,a}
//   ponto          : active-low decimal point
//   indice         : current digit index
//   fim_varredura  : one-cycle pulse when indice wraps to 0
module varredura_display
  import pkg_display::*;
#(
  parameter int unsigned NUM_DIGITOS = 4,
  parameter int unsigned DIV_REFRESH = 50000,
  parameter int unsigned GUARDA      = 2,
  localparam int unsigned IW = largura_indice(NUM_DIGITOS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     habilita,
  input  logic [4*NUM_DIGITOS-1:0] dados,
  input  logic [NUM_DIGITOS-1:0]   apagar,
  input  logic [NUM_DIGITOS-1:0]   pontos,
`ifdef VARREDURA_DIMMER_EN
  input  logic [3:0]               brilho,
`endif
  output logic [NUM_DIGITOS-1:0]   anodos,
  output logic [6:0]               segmentos,
  output logic                     ponto,
  output logic [IW-1:0]            indice,
  output logic                     fim_varredura
);

  localparam int unsigned CW = $clog2(DIV_REFRESH);

  logic [CW-1:0]          cnt, cnt_nxt;
  logic [IW-1:0]          indice_nxt;
  logic                   fim_nxt;
  logic [NUM_DIGITOS-1:0] anodos_nxt;
  logic [6:0]             seg_nxt;
  logic                   ponto_nxt;
  logic [3:0]             nibble_c;
  logic [6:0]             seg_dec_c;
  logic                   anodo_on_c;
  logic                   fim_slot_c;
  logic                   ultimo_c;

`ifdef VARREDURA_DIMMER_EN
  logic [3:0] pwm;
`endif

  // Nibble of the digit currently selected
  always_comb begin
    nibble_c = dados[4*int'(indice) +: 4];
  end

  decodificador_7seg u_dec (
    .nibble (nibble_c),
    .seg_c  (seg_dec_c)
  );

  // Slot sequencing and output computation for the next cycle
  always_comb begin
    cnt_nxt    = cnt;
    indice_nxt = indice;
    fim_nxt    = 1'b0;
    anodos_nxt = '1;
    seg_nxt    = SEG_APAGADO;
    ponto_nxt  = 1'b1;

    fim_slot_c = (cnt == CW'(DIV_REFRESH - 1));
    ultimo_c   = (indice == IW'(NUM_DIGITOS - 1));

    if (habilita) begin
      if (fim_slot_c) begin
        cnt_nxt    = '0;
        indice_nxt = ultimo_c ? '0 : indice + IW'(1);
        fim_nxt    = ultimo_c;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end

    anodo_on_c = habilita && !apagar[indice] && (32'(cnt) >= GUARDA);
`ifdef VARREDURA_DIMMER_EN
    anodo_on_c = anodo_on_c && (pwm <= brilho);
`endif

    // Segments follow the anode so nothing lights while the digit is off
    if (anodo_on_c) begin
      anodos_nxt = ~(NUM_DIGITOS'(1) << indice);
      seg_nxt    = seg_dec_c;
      ponto_nxt  = ~pontos[indice];
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      indice        <= '0;
      fim_varredura <= 1'b0;
      anodos        <= '1;
      segmentos     <= SEG_APAGADO;
      ponto         <= 1'b1;
    end else begin
      cnt           <= cnt_nxt;
      indice        <= indice_nxt;
      fim_varredura <= fim_nxt;
      anodos        <= anodos_nxt;
      segmentos     <= seg_nxt;
      ponto         <= ponto_nxt;
    end
  end

`ifdef VARREDURA_DIMMER_EN
  // Free-running brightness counter, paused while scanning is frozen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm <= '0;
    end else if (habilita) begin
      pwm <= pwm + 4'(1);
    end
  end
`endif

endmodule
